// File: rtl/qam_pkg.sv
// Shared types for the 4-QAM mapper/demapper pair: constellation level,
// symbol encodings, FIFO entry layout and serializer states.
package qam_pkg;

    localparam int LEVEL = 3;

    typedef logic [1:0] sym_t;

    // Bit pairs as placed on the constellation by the mapper, named by (I,Q) sign
    localparam sym_t SYM_NP = 2'b00;
    localparam sym_t SYM_PP = 2'b01;
    localparam sym_t SYM_PN = 2'b11;
    localparam sym_t SYM_NN = 2'b10;

    typedef struct packed {
        logic d1;
        logic d0;
        logic lowconf;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MSB  = 2'd1,
        ST_LSB  = 2'd2
    } state_e;

endpackage

// File: rtl/qam_sym_fifo.sv
// Small synchronous FIFO holding decided symbols; exposes the head and the
// entry behind it so the serializer can move to the next symbol without a bubble.
module qam_sym_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [WIDTH-1:0]           next_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_ptr_q + PTR_ONE];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/qam_demapper.sv
// 4-QAM hard-decision demapper: slices I/Q samples into bit pairs, queues them
// and re-serializes MSB-first onto a valid/ready bit stream.
module qam_demapper
    import qam_pkg::*;
#(
    parameter int W      = 3,
    parameter int THRESH = 2,
    parameter int DEPTH  = 4,
    parameter int CW     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] i_in,
    input  logic signed [W-1:0] q_in,
    input  logic                sym_valid,
    output logic                sym_ready,
    output logic                bit_out,
    output logic                bit_lowconf,
    output logic                bit_valid,
    input  logic                bit_ready,
    output logic [CW-1:0]       sym_count,
    output logic [CW-1:0]       lowconf_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W:0]  i_ext, q_ext, i_mag, q_mag;
    logic        i_pos, lowconf, accept;
    sym_t        in_sym;
    entry_t      in_entry, head, next_entry, load_entry;
    logic        fifo_full, fifo_empty, pop;
    logic [AW:0] occupancy;

    state_e      state_q, state_d;
    logic        bit_out_q, bit_out_d;
    logic        bit_lc_q, bit_lc_d;
    logic        bit_valid_q, bit_valid_d;
    logic        pend_d0_q, pend_d0_d;
    logic [CW-1:0] sym_count_q, lc_count_q;

    // One extra bit keeps the most negative sample's magnitude representable
    assign i_ext = {i_in[W-1], i_in};
    assign q_ext = {q_in[W-1], q_in};
    assign i_mag = i_in[W-1] ? (~i_ext + (W+1)'(1)) : i_ext;
    assign q_mag = q_in[W-1] ? (~q_ext + (W+1)'(1)) : q_ext;

    assign i_pos    = !i_in[W-1] && (i_in != '0);
    assign in_sym   = {q_in[W-1], i_pos};
    assign lowconf  = (int'(i_mag) < THRESH) || (int'(q_mag) < THRESH);
    assign in_entry = '{d1: in_sym[1], d0: in_sym[0], lowconf: lowconf};

    assign sym_ready = !fifo_full;
    assign accept    = sym_valid && sym_ready;

    qam_sym_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_ni      (reset),
        .push_i      (accept),
        .push_data_i (in_entry),
        .pop_i       (pop),
        .head_o      (head),
        .next_o      (next_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (occupancy)
    );

    // Symbol to load when starting an MSB: the head from IDLE; after a pop the
    // entry behind it, or the one being pushed on that same edge if none remains
    always_comb begin
        load_entry = head;
        if (state_q == ST_LSB) begin
            load_entry = (occupancy > (AW+1)'(1)) ? next_entry : in_entry;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_out_d   = bit_out_q;
        bit_lc_d    = bit_lc_q;
        bit_valid_d = bit_valid_q;
        pend_d0_d   = pend_d0_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d     = ST_MSB;
                    bit_out_d   = load_entry.d1;
                    bit_lc_d    = load_entry.lowconf;
                    pend_d0_d   = load_entry.d0;
                    bit_valid_d = 1'b1;
                end
            end
            ST_MSB: begin
                if (bit_ready) begin
                    state_d   = ST_LSB;
                    bit_out_d = pend_d0_q;
                end
            end
            ST_LSB: begin
                if (bit_ready) begin
                    pop = 1'b1;
                    if ((occupancy > (AW+1)'(1)) || accept) begin
                        state_d   = ST_MSB;
                        bit_out_d = load_entry.d1;
                        bit_lc_d  = load_entry.lowconf;
                        pend_d0_d = load_entry.d0;
                    end else begin
                        state_d     = ST_IDLE;
                        bit_out_d   = 1'b0;
                        bit_lc_d    = 1'b0;
                        bit_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                bit_out_d   = 1'b0;
                bit_lc_d    = 1'b0;
                bit_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_out_q   <= 1'b0;
            bit_lc_q    <= 1'b0;
            bit_valid_q <= 1'b0;
            pend_d0_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_out_q   <= bit_out_d;
            bit_lc_q    <= bit_lc_d;
            bit_valid_q <= bit_valid_d;
            pend_d0_q   <= pend_d0_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_count_q <= '0;
            lc_count_q  <= '0;
        end else if (accept) begin
            sym_count_q <= sym_count_q + CW'(1);
            if (lowconf) lc_count_q <= lc_count_q + CW'(1);
        end
    end

    assign bit_out       = bit_out_q;
    assign bit_lowconf   = bit_lc_q;
    assign bit_valid     = bit_valid_q;
    assign sym_count     = sym_count_q;
    assign lowconf_count = lc_count_q;

endmodule

// File: tb/tb_qam_demapper.sv
// Directed bench for qam_demapper: ideal and noisy symbols, backpressure,
// toggling ready and reset while a symbol is being serialized.
module tb_qam_demapper;
    import qam_pkg::*;

    localparam int W      = 3;
    localparam int THRESH = 2;
    localparam int DEPTH  = 4;
    localparam int CW     = 16;

    logic                clk;
    logic                reset;
    logic signed [W-1:0] i_in, q_in;
    logic                sym_valid, sym_ready;
    logic                bit_out, bit_lowconf, bit_valid, bit_ready;
    logic [CW-1:0]       sym_count, lowconf_count;

    int   checks = 0;
    int   errors = 0;
    int   symI [8];
    int   symQ [8];
    logic expBit [16];
    logic expLc  [16];

    qam_demapper #(
        .W      (W),
        .THRESH (THRESH),
        .DEPTH  (DEPTH),
        .CW     (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_in          (i_in),
        .q_in          (q_in),
        .sym_valid     (sym_valid),
        .sym_ready     (sym_ready),
        .bit_out       (bit_out),
        .bit_lowconf   (bit_lowconf),
        .bit_valid     (bit_valid),
        .bit_ready     (bit_ready),
        .sym_count     (sym_count),
        .lowconf_count (lowconf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic doReset();
        reset     = 1'b0;
        sym_valid = 1'b0;
        bit_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // Feeds nSym symbols back to back with bit_ready high and checks the bit stream
    task automatic applyStimulus(input int nSym, input int expLcCount, input string tag);
        bit_ready = 1'b1;
        for (int c = 0; c <= 2 * nSym + 1; c++) begin
            if (c < nSym) begin
                i_in      = W'(symI[c]);
                q_in      = W'(symQ[c]);
                sym_valid = 1'b1;
            end else begin
                sym_valid = 1'b0;
            end
            tick();
            if (c == 0 || c > 2 * nSym) begin
                checkOutput({tag, "_idle"}, int'(bit_valid), 0);
            end else begin
                checkOutput({tag, "_valid"}, int'(bit_valid), 1);
                checkOutput({tag, "_bit"}, int'(bit_out), int'(expBit[c-1]));
                checkOutput({tag, "_lc"}, int'(bit_lowconf), int'(expLc[c-1]));
            end
        end
        checkOutput({tag, "_symcount"}, int'(sym_count), nSym);
        checkOutput({tag, "_lccount"}, int'(lowconf_count), expLcCount);
    endtask

    initial begin
        int idx;
        logic rdy;

        i_in      = '0;
        q_in      = '0;
        sym_valid = 1'b0;
        bit_ready = 1'b0;
        reset     = 1'b0;

        $display("[TB] reset with random inputs");
        for (int k = 0; k < 5; k++) begin
            i_in      = W'($urandom);
            q_in      = W'($urandom);
            sym_valid = 1'($urandom);
            bit_ready = 1'($urandom);
            tick();
            checkOutput("rst_valid", int'(bit_valid), 0);
            checkOutput("rst_bit", int'(bit_out), 0);
            checkOutput("rst_symcount", int'(sym_count), 0);
        end
        sym_valid = 1'b0;
        reset     = 1'b1;
        tick();
        checkOutput("rst_ready", int'(sym_ready), 1);
        checkOutput("rst_lc", int'(bit_lowconf), 0);
        checkOutput("rst_lccount", int'(lowconf_count), 0);

        $display("[TB] ideal constellation points");
        doReset();
        symI[0] = -LEVEL; symQ[0] =  LEVEL;
        symI[1] =  LEVEL; symQ[1] =  LEVEL;
        symI[2] =  LEVEL; symQ[2] = -LEVEL;
        symI[3] = -LEVEL; symQ[3] = -LEVEL;
        expBit[0] = 0; expBit[1] = 0; expBit[2] = 0; expBit[3] = 1;
        expBit[4] = 1; expBit[5] = 1; expBit[6] = 1; expBit[7] = 0;
        for (int k = 0; k < 8; k++) expLc[k] = 1'b0;
        applyStimulus(4, 0, "ideal");

        $display("[TB] noisy samples and ties");
        doReset();
        symI[0] =  1; symQ[0] = -2;
        symI[1] =  0; symQ[1] =  0;
        symI[2] = -4; symQ[2] =  3;
        expBit[0] = 1; expBit[1] = 1; expBit[2] = 0;
        expBit[3] = 0; expBit[4] = 0; expBit[5] = 0;
        expLc[0] = 1; expLc[1] = 1; expLc[2] = 1;
        expLc[3] = 1; expLc[4] = 0; expLc[5] = 0;
        applyStimulus(3, 2, "noise");

        $display("[TB] backpressure");
        doReset();
        symI[0] =  3; symQ[0] =  3;
        symI[1] = -3; symQ[1] = -3;
        symI[2] =  3; symQ[2] = -3;
        symI[3] = -3; symQ[3] =  3;
        symI[4] =  3; symQ[4] =  3;
        expBit[0] = 0; expBit[1] = 1; expBit[2] = 1; expBit[3] = 0;
        expBit[4] = 1; expBit[5] = 1; expBit[6] = 0; expBit[7] = 0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("bp_ready_fill", int'(sym_ready), 1);
            i_in      = W'(symI[k]);
            q_in      = W'(symQ[k]);
            sym_valid = 1'b1;
            tick();
        end
        checkOutput("bp_full", int'(sym_ready), 0);
        i_in = W'(symI[4]);
        q_in = W'(symQ[4]);
        repeat (3) tick();
        checkOutput("bp_still_full", int'(sym_ready), 0);
        checkOutput("bp_symcount", int'(sym_count), 4);
        sym_valid = 1'b0;
        bit_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            checkOutput("bp_valid", int'(bit_valid), 1);
            checkOutput("bp_bit", int'(bit_out), int'(expBit[b]));
            if (b == 1) checkOutput("bp_ready_after_msb", int'(sym_ready), 0);
            if (b == 2) checkOutput("bp_ready_after_lsb", int'(sym_ready), 1);
            tick();
        end
        checkOutput("bp_drained", int'(bit_valid), 0);
        checkOutput("bp_symcount_end", int'(sym_count), 4);

        $display("[TB] toggling bit_ready");
        doReset();
        symI[0] =  3; symQ[0] = -3;
        symI[1] = -3; symQ[1] =  3;
        symI[2] =  3; symQ[2] =  3;
        expBit[0] = 1; expBit[1] = 1; expBit[2] = 0;
        expBit[3] = 0; expBit[4] = 0; expBit[5] = 1;
        for (int k = 0; k < 3; k++) begin
            i_in      = W'(symI[k]);
            q_in      = W'(symQ[k]);
            sym_valid = 1'b1;
            tick();
        end
        sym_valid = 1'b0;
        idx = 0;
        rdy = 1'b1;
        for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
            checkOutput("tog_valid", int'(bit_valid), 1);
            checkOutput("tog_bit", int'(bit_out), int'(expBit[idx]));
            bit_ready = rdy;
            tick();
            if (rdy) idx++;
            rdy = !rdy;
        end
        checkOutput("tog_bits_done", idx, 6);
        checkOutput("tog_idle", int'(bit_valid), 0);
        checkOutput("tog_symcount", int'(sym_count), 3);

        $display("[TB] reset mid-symbol");
        doReset();
        symI[0] =  3; symQ[0] =  3;
        symI[1] = -3; symQ[1] = -3;
        symI[2] =  3; symQ[2] = -3;
        for (int k = 0; k < 3; k++) begin
            i_in      = W'(symI[k]);
            q_in      = W'(symQ[k]);
            sym_valid = 1'b1;
            tick();
        end
        sym_valid = 1'b0;
        bit_ready = 1'b1;
        tick();
        bit_ready = 1'b0;
        tick();
        checkOutput("mid_lsb_valid", int'(bit_valid), 1);
        checkOutput("mid_lsb_bit", int'(bit_out), 1);
        checkOutput("mid_symcount", int'(sym_count), 3);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid_rst_valid", int'(bit_valid), 0);
        checkOutput("mid_rst_bit", int'(bit_out), 0);
        checkOutput("mid_rst_symcount", int'(sym_count), 0);
        checkOutput("mid_rst_ready", int'(sym_ready), 1);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("mid_post_ready", int'(sym_ready), 1);
        checkOutput("mid_post_valid", int'(bit_valid), 0);
        symI[0] = 3; symQ[0] = -3;
        expBit[0] = 1; expBit[1] = 1;
        expLc[0] = 0; expLc[1] = 0;
        applyStimulus(1, 0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
